// File: rtl/diag_scaler.sv
// diag_scaler -- diagonal scaling stage of the LDL^T solve chain, Z = D^-1 * Y.
//
// Sits between the forward pass (L*Y = B) and the backward pass (L^T*X = Z).
// D is the diagonal of the packed factor A (unit diagonal of L is implicit).
// Phase 1 reads each row i of A, extracts d_i = A[i][i] and divides 1.0 / d_i
// on the shared fp divider, storing the reciprocal vector.
// Phase 2 reads each column k of Y and multiplies it by the reciprocal vector
// on the shared vector-mult ALU (elementwise mode).
// Each result column is then written out one element per cycle.
//
// Optional feature macro: DIAG_SCALER_ZERO_CHECK_EN
//   Enables the zero-diagonal bypass and adds the sticky diag_zero_err output.
//
// Ports:
//   clk, rst                       clock; asynchronous active-low reset
//   start / finished               job start (IDLE only) / one-cycle done pulse
//   a_row_addr(_ready)             row read request to A
//   a_row_valid, a_row_out         row read response
//   div_num, div_den, div_ready    divide request (1.0 / d_i)
//   div_out, div_valid             divide response
//   vector_mult_in_a/_in_b/_ready  elementwise multiply request (Y column, 1/d)
//   vector_mult_out/_valid         multiply response
//   dot_product_mode               tied 0 (elementwise mode)
//   y_col_addr(_ready)             column read request to Y
//   y_col_valid, y_col_out         column read response
//   z_write_row/col_addr, z_write_data, z_write_ready   Z element write port
//   diag_zero_err                  sticky zero-diagonal flag (macro builds only)

module diag_scaler #(
   parameter int unsigned      N      = 4,
   parameter int unsigned      M      = 3,
   parameter int unsigned      WIDTH  = 32,
   parameter logic [WIDTH-1:0] FP_ONE = 32'h3F800000,
   localparam int              AW     = (N > 1) ? $clog2(N) : 1,
   localparam int              MW     = (M > 1) ? $clog2(M) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic                 finished,
   output logic [AW-1:0]        a_row_addr,
   output logic                 a_row_addr_ready,
   input  logic                 a_row_valid,
   input  logic [N*WIDTH-1:0]   a_row_out,
   output logic [WIDTH-1:0]     div_num,
   output logic [WIDTH-1:0]     div_den,
   output logic                 div_ready,
   input  logic [WIDTH-1:0]     div_out,
   input  logic                 div_valid,
   output logic [N*WIDTH-1:0]   vector_mult_in_a,
   output logic [N*WIDTH-1:0]   vector_mult_in_b,
   output logic                 vector_mult_ready,
   input  logic [N*WIDTH-1:0]   vector_mult_out,
   input  logic                 vector_mult_valid,
   output logic                 dot_product_mode,
   output logic [MW-1:0]        y_col_addr,
   output logic                 y_col_addr_ready,
   input  logic                 y_col_valid,
   input  logic [N*WIDTH-1:0]   y_col_out,
   output logic [AW-1:0]        z_write_row_addr,
   output logic [MW-1:0]        z_write_col_addr,
   output logic [WIDTH-1:0]     z_write_data,
`ifdef DIAG_SCALER_ZERO_CHECK_EN
   output logic                 diag_zero_err,
`endif
   output logic                 z_write_ready
);

   localparam logic [AW-1:0] I_LAST = AW'(N - 1);
   localparam logic [MW-1:0] K_LAST = MW'(M - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_D_REQ, S_D_WAIT, S_D_ISSUE, S_D_DIV,
      S_Y_REQ, S_Y_WAIT, S_V_ISSUE, S_V_WAIT, S_WRITE, S_DONE
   } state_e;

   state_e             state_q, state_d;
   logic [AW-1:0]      i_q, i_d;        // diagonal index
   logic [AW-1:0]      j_q, j_d;        // row index within the write burst
   logic [MW-1:0]      k_q, k_d;        // column index
   logic [WIDTH-1:0]   d_q, d_d;        // captured diagonal element
   logic [N*WIDTH-1:0] inv_q, inv_d;    // reciprocal vector, element i at [i*WIDTH]
   logic [N*WIDTH-1:0] ybuf_q, ybuf_d;
   logic [N*WIDTH-1:0] zbuf_q, zbuf_d;
`ifdef DIAG_SCALER_ZERO_CHECK_EN
   logic               err_q, err_d;
   assign diag_zero_err = err_q;
`endif

   logic [WIDTH-1:0] a_diag;
   assign a_diag = a_row_out[i_q*WIDTH +: WIDTH];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         i_q     <= '0;
         j_q     <= '0;
         k_q     <= '0;
         d_q     <= '0;
         // NOTE: the reciprocal and data buffers are plain flops, so they take the
         // async reset too; this keeps X out of the datapath after power-up.
         inv_q   <= '0;
         ybuf_q  <= '0;
         zbuf_q  <= '0;
`ifdef DIAG_SCALER_ZERO_CHECK_EN
         err_q   <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking only in clocked blocks, so every register sees the
         // pre-edge value of every other register regardless of statement order.
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         k_q     <= k_d;
         d_q     <= d_d;
         inv_q   <= inv_d;
         ybuf_q  <= ybuf_d;
         zbuf_q  <= zbuf_d;
`ifdef DIAG_SCALER_ZERO_CHECK_EN
         err_q   <= err_d;
`endif
      end
   end

   // Outputs are decoded from state only; data outputs are held at zero outside
   // the cycle that strobes them, so a reset zeroes every output immediately.
   always_comb begin
      // NOTE: every signal gets a default before the case, otherwise paths that
      // do not assign it would infer a latch.
      state_d           = state_q;
      i_d               = i_q;
      j_d               = j_q;
      k_d               = k_q;
      d_d               = d_q;
      inv_d             = inv_q;
      ybuf_d            = ybuf_q;
      zbuf_d            = zbuf_q;
`ifdef DIAG_SCALER_ZERO_CHECK_EN
      err_d             = err_q;
`endif
      finished          = 1'b0;
      a_row_addr        = '0;
      a_row_addr_ready  = 1'b0;
      div_num           = '0;
      div_den           = '0;
      div_ready         = 1'b0;
      vector_mult_in_a  = '0;
      vector_mult_in_b  = '0;
      vector_mult_ready = 1'b0;
      dot_product_mode  = 1'b0;
      y_col_addr        = '0;
      y_col_addr_ready  = 1'b0;
      z_write_row_addr  = '0;
      z_write_col_addr  = '0;
      z_write_data      = '0;
      z_write_ready     = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            i_d = '0;
            j_d = '0;
            k_d = '0;
            if (start) begin
               state_d = S_D_REQ;
`ifdef DIAG_SCALER_ZERO_CHECK_EN
               err_d   = 1'b0;
`endif
            end
         end
         S_D_REQ: begin
            a_row_addr       = i_q;
            a_row_addr_ready = 1'b1;
            state_d          = S_D_WAIT;
         end
         S_D_WAIT: begin
            if (a_row_valid) begin
               d_d     = a_diag;
               state_d = S_D_ISSUE;
`ifdef DIAG_SCALER_ZERO_CHECK_EN
               // +/-0.0 would produce inf: store 0 and skip the divider.
               if (a_diag[WIDTH-2:0] == '0) begin
                  inv_d[i_q*WIDTH +: WIDTH] = '0;
                  err_d                     = 1'b1;
                  if (i_q == I_LAST) begin
                     state_d = S_Y_REQ;
                  end else begin
                     i_d     = i_q + 1'b1;
                     state_d = S_D_REQ;
                  end
               end
`endif
            end
         end
         S_D_ISSUE: begin
            div_ready = 1'b1;
            div_num   = FP_ONE;
            div_den   = d_q;
            state_d   = S_D_DIV;
         end
         S_D_DIV: begin
            if (div_valid) begin
               inv_d[i_q*WIDTH +: WIDTH] = div_out;
               if (i_q == I_LAST) begin
                  state_d = S_Y_REQ;
               end else begin
                  i_d     = i_q + 1'b1;
                  state_d = S_D_REQ;
               end
            end
         end
         S_Y_REQ: begin
            y_col_addr       = k_q;
            y_col_addr_ready = 1'b1;
            state_d          = S_Y_WAIT;
         end
         S_Y_WAIT: begin
            if (y_col_valid) begin
               ybuf_d  = y_col_out;
               state_d = S_V_ISSUE;
            end
         end
         S_V_ISSUE: begin
            vector_mult_ready = 1'b1;
            vector_mult_in_a  = ybuf_q;
            vector_mult_in_b  = inv_q;
            state_d           = S_V_WAIT;
         end
         S_V_WAIT: begin
            if (vector_mult_valid) begin
               zbuf_d  = vector_mult_out;
               j_d     = '0;
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            z_write_ready    = 1'b1;
            z_write_row_addr = j_q;
            z_write_col_addr = k_q;
            z_write_data     = zbuf_q[j_q*WIDTH +: WIDTH];
            j_d              = j_q + 1'b1;
            if (j_q == I_LAST) begin
               if (k_q == K_LAST) begin
                  state_d = S_DONE;
               end else begin
                  k_d     = k_q + 1'b1;
                  state_d = S_Y_REQ;
               end
            end
         end
         S_DONE: begin
            finished = 1'b1;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_diag_scaler.sv
// tb_diag_scaler -- self-checking bench for diag_scaler (N=4, M=3, WIDTH=32).
// Memory, divider and vector-mult ports are modelled by responders with fixed
// or random latency. Expected Z comes from Z = D^-1 * Y evaluated with real
// arithmetic, or from hand-written constants for the identity and scaling jobs.
// When DIAG_SCALER_ZERO_CHECK_EN is defined, the zero-diagonal job also runs.

module tb_diag_scaler;

   localparam int          N   = 4;
   localparam int          M   = 3;
   localparam int          W   = 32;
   localparam int          AW  = 2;
   localparam int          MW  = 2;
   localparam logic [31:0] ONE = 32'h3F800000;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           start = 1'b0;
   logic           finished;
   logic [AW-1:0]  a_row_addr;
   logic           a_row_addr_ready;
   logic           a_row_valid = 1'b0;
   logic [N*W-1:0] a_row_out = '0;
   logic [W-1:0]   div_num, div_den;
   logic           div_ready;
   logic [W-1:0]   div_out = '0;
   logic           div_valid = 1'b0;
   logic [N*W-1:0] vector_mult_in_a, vector_mult_in_b;
   logic           vector_mult_ready;
   logic [N*W-1:0] vector_mult_out = '0;
   logic           vector_mult_valid = 1'b0;
   logic           dot_product_mode;
   logic [MW-1:0]  y_col_addr;
   logic           y_col_addr_ready;
   logic           y_col_valid = 1'b0;
   logic [N*W-1:0] y_col_out = '0;
   logic [AW-1:0]  z_write_row_addr;
   logic [MW-1:0]  z_write_col_addr;
   logic [W-1:0]   z_write_data;
   logic           z_write_ready;
`ifdef DIAG_SCALER_ZERO_CHECK_EN
   logic           diag_zero_err;
`endif

   diag_scaler #(.N(N), .M(M), .WIDTH(W), .FP_ONE(ONE)) dut (
      .clk(clk), .rst(rst), .start(start), .finished(finished),
      .a_row_addr(a_row_addr), .a_row_addr_ready(a_row_addr_ready),
      .a_row_valid(a_row_valid), .a_row_out(a_row_out),
      .div_num(div_num), .div_den(div_den), .div_ready(div_ready),
      .div_out(div_out), .div_valid(div_valid),
      .vector_mult_in_a(vector_mult_in_a), .vector_mult_in_b(vector_mult_in_b),
      .vector_mult_ready(vector_mult_ready), .vector_mult_out(vector_mult_out),
      .vector_mult_valid(vector_mult_valid), .dot_product_mode(dot_product_mode),
      .y_col_addr(y_col_addr), .y_col_addr_ready(y_col_addr_ready),
      .y_col_valid(y_col_valid), .y_col_out(y_col_out),
      .z_write_row_addr(z_write_row_addr), .z_write_col_addr(z_write_col_addr),
      .z_write_data(z_write_data),
`ifdef DIAG_SCALER_ZERO_CHECK_EN
      .diag_zero_err(diag_zero_err),
`endif
      .z_write_ready(z_write_ready)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // ---------------- fp32 <-> real helpers (normal numbers, truncating) ------
   function automatic real f2r(input logic [31:0] f);
      logic [63:0] b;
      logic [10:0] e;
      if (f[30:23] == 8'd0)       b = {f[31], 63'd0};
      else if (f[30:23] == 8'hFF) b = {f[31], 11'h7FF, 52'd0};
      else begin
         e = 11'(f[30:23]) + 11'd896;
         b = {f[31], e, f[22:0], 29'd0};
      end
      return $bitstoreal(b);
   endfunction

   function automatic logic [31:0] r2f(input real r);
      logic [63:0] b;
      int          e;
      b = $realtobits(r);
      e = int'(b[62:52]) - 896;
      if (b[62:52] == 11'h7FF || e >= 255) return {b[63], 8'hFF, 23'd0};
      if (e <= 0) return {b[63], 31'd0};
      return {b[63], 8'(e), b[51:29]};
   endfunction

   function automatic logic [31:0] rand_fp();
      return {1'($urandom), 8'($urandom_range(140, 110)), 23'($urandom)};
   endfunction

   // ---------------- reference model ----------------------------------------
   logic [31:0] a_mat [N][N];
   logic [31:0] y_mat [N][M];
   logic [31:0] z_exp [N][M];

   function automatic logic [31:0] recip(input logic [31:0] d);
`ifdef DIAG_SCALER_ZERO_CHECK_EN
      if (d[30:0] == 31'd0) return 32'd0;
`endif
      return r2f(1.0 / f2r(d));
   endfunction

   task automatic build_model();
      for (int r = 0; r < N; r++)
         for (int k = 0; k < M; k++)
            z_exp[r][k] = r2f(f2r(recip(a_mat[r][r])) * f2r(y_mat[r][k]));
   endtask

   task automatic randomize_data();
      for (int r = 0; r < N; r++) begin
         for (int c = 0; c < N; c++) a_mat[r][c] = rand_fp();
         for (int k = 0; k < M; k++) y_mat[r][k] = rand_fp();
      end
   endtask

   // ---------------- port responders ----------------------------------------
   int lm = 1, ld = 4, lv = 3;
   bit rand_lat = 1'b0;
   bit inj_vm   = 1'b0;
   int div_reqs = 0;

   function automatic int pick_lat(input int fixed);
      return rand_lat ? int'($urandom_range(6, 1)) : fixed;
   endfunction

   initial begin : a_port
      int left;
      bit busy;
      logic [AW-1:0] addr;
      busy = 1'b0;
      forever begin
         @(negedge clk);
         a_row_valid = 1'b0;
         if (!rst) busy = 1'b0;
         else if (busy) begin
            check("a_row_one_outstanding", a_row_addr_ready, 0);
            left--;
            if (left == 0) begin
               for (int c = 0; c < N; c++) a_row_out[c*W +: W] = a_mat[addr][c];
               a_row_valid = 1'b1;
               busy        = 1'b0;
            end
         end else if (a_row_addr_ready) begin
            addr = a_row_addr;
            left = pick_lat(lm);
            busy = 1'b1;
         end
      end
   end

   initial begin : div_port
      int left;
      bit busy;
      logic [31:0] q;
      busy = 1'b0;
      forever begin
         @(negedge clk);
         div_valid = 1'b0;
         if (!rst) busy = 1'b0;
         else if (busy) begin
            check("div_one_outstanding", div_ready, 0);
            left--;
            if (left == 0) begin
               div_out   = q;
               div_valid = 1'b1;
               busy      = 1'b0;
            end
         end else if (div_ready) begin
            check("div_num", div_num, ONE);
            div_reqs++;
            q    = r2f(f2r(div_num) / f2r(div_den));
            left = pick_lat(ld);
            busy = 1'b1;
         end
      end
   end

   initial begin : y_port
      int left;
      bit busy;
      logic [MW-1:0] addr;
      busy = 1'b0;
      forever begin
         @(negedge clk);
         y_col_valid = 1'b0;
         if (!rst) busy = 1'b0;
         else if (busy) begin
            check("y_col_one_outstanding", y_col_addr_ready, 0);
            left--;
            if (left == 0) begin
               for (int r = 0; r < N; r++) y_col_out[r*W +: W] = y_mat[r][addr];
               y_col_valid = 1'b1;
               busy        = 1'b0;
            end
         end else if (y_col_addr_ready) begin
            addr = y_col_addr;
            left = pick_lat(lm);
            busy = 1'b1;
         end
      end
   end

   initial begin : vm_port
      int left;
      bit busy;
      logic [N*W-1:0] q;
      busy = 1'b0;
      forever begin
         @(negedge clk);
         vector_mult_valid = 1'b0;
         if (!rst) busy = 1'b0;
         else begin
            if (inj_vm) begin
               // Unsolicited product pulse while the DUT is dividing.
               vector_mult_out   = {N{32'hDEADBEEF}};
               vector_mult_valid = 1'b1;
               inj_vm            = 1'b0;
            end
            if (busy) begin
               check("vmult_one_outstanding", vector_mult_ready, 0);
               left--;
               if (left == 0) begin
                  vector_mult_out   = q;
                  vector_mult_valid = 1'b1;
                  busy              = 1'b0;
               end
            end else if (vector_mult_ready) begin
               check("dot_product_mode", dot_product_mode, 0);
               for (int e = 0; e < N; e++)
                  q[e*W +: W] = r2f(f2r(vector_mult_in_a[e*W +: W]) * f2r(vector_mult_in_b[e*W +: W]));
               left = pick_lat(lv);
               busy = 1'b1;
            end
         end
      end
   end

   // ---------------- helpers over DUT outputs --------------------------------
   function automatic int out_ones();
      return $countones({finished, a_row_addr, a_row_addr_ready, div_num, div_den,
                         div_ready, vector_mult_in_a, vector_mult_in_b,
                         vector_mult_ready, dot_product_mode, y_col_addr,
                         y_col_addr_ready, z_write_row_addr, z_write_col_addr,
                         z_write_data, z_write_ready
`ifdef DIAG_SCALER_ZERO_CHECK_EN
                         , diag_zero_err
`endif
                         });
   endfunction

   function automatic int strobes();
      return $countones({finished, a_row_addr_ready, div_ready, vector_mult_ready,
                         y_col_addr_ready, z_write_ready});
   endfunction

   typedef struct {
      int          row;
      int          col;
      logic [31:0] data;
      int          cyc;
   } wr_t;

   // One job: pulse start, collect writes until finished, then compare against
   // z_exp. exp_lat < 0 skips the latency check.
   task automatic run_job(input string tag, input int exp_lat, input bit spurious,
                          input bit abort_mid);
      wr_t wq[$];
      wr_t w;
      int  s_cyc;
      bit  done;
      bit  aborted;
      div_reqs = 0;
      done     = 1'b0;
      aborted  = 1'b0;
      start    = 1'b1;
      s_cyc    = cyc;
      @(negedge clk);
      start = 1'b0;
`ifdef DIAG_SCALER_ZERO_CHECK_EN
      check({tag, "_err_cleared"}, diag_zero_err, 0);
`endif
      for (int t = 0; t < 4000 && !done && !aborted; t++) begin
         start = 1'b0;
         if (z_write_ready) begin
            w.row  = int'(z_write_row_addr);
            w.col  = int'(z_write_col_addr);
            w.data = z_write_data;
            w.cyc  = cyc;
            wq.push_back(w);
            if (abort_mid && w.col == 1 && w.row == 1) begin
               rst = 1'b0;
               #1;
               check({tag, "_rst_outputs"}, out_ones(), 0);
               check({tag, "_writes_before_rst"}, wq.size(), N + 2);
               aborted = 1'b1;
            end
         end
         if (!aborted && finished) begin
            if (exp_lat >= 0) check({tag, "_latency"}, cyc - s_cyc, exp_lat);
            done = 1'b1;
         end
         if (spurious && cyc == s_cyc + 4)  inj_vm = 1'b1;
         if (spurious && cyc == s_cyc + 20) start  = 1'b1;
         if (!done && !aborted) @(negedge clk);
      end
      start = 1'b0;
      if (abort_mid) begin
         check({tag, "_aborted"}, aborted, 1);
         repeat (2) @(negedge clk);
         rst = 1'b1;
         for (int q = 0; q < 3; q++) begin
            @(negedge clk);
            check({tag, "_quiet_after_rst"}, strobes(), 0);
         end
         return;
      end
      check({tag, "_finished"}, done, 1);
      check({tag, "_nwrites"}, wq.size(), N * M);
      foreach (wq[x]) begin
         check({tag, "_row_order"}, wq[x].row, x % N);
         check({tag, "_col_order"}, wq[x].col, x / N);
         if (x % N != 0) check({tag, "_gapless"}, wq[x].cyc - wq[x-1].cyc, 1);
         if (x < N * M)
            check($sformatf("%s_z%0d_%0d", tag, x % N, x / N), wq[x].data, z_exp[x % N][x / N]);
      end
      @(negedge clk);
   endtask

   // ---------------- main sequence -------------------------------------------
   initial begin
      repeat (3) @(negedge clk);
      check("reset_outputs", out_ones(), 0);
      rst = 1'b1;
      @(negedge clk);
      check("post_reset_quiet", strobes(), 0);

      // Identity: Z == Y, finished at cycle 59.
      for (int r = 0; r < N; r++) begin
         for (int c = 0; c < N; c++) a_mat[r][c] = (r == c) ? ONE : 32'd0;
         for (int k = 0; k < M; k++) begin
            y_mat[r][k] = r2f(real'(r * M + k + 1));
            z_exp[r][k] = y_mat[r][k];
         end
      end
      run_job("ident", 59, 1'b0, 1'b0);
      check("ident_div_reqs", div_reqs, N);

      // Scaling: diag {2, 4, 0.5, -1}, Y all 1.0.
      randomize_data();
      a_mat[0][0] = 32'h40000000;
      a_mat[1][1] = 32'h40800000;
      a_mat[2][2] = 32'h3F000000;
      a_mat[3][3] = 32'hBF800000;
      for (int k = 0; k < M; k++) begin
         for (int r = 0; r < N; r++) y_mat[r][k] = ONE;
         z_exp[0][k] = 32'h3F000000;
         z_exp[1][k] = 32'h3E800000;
         z_exp[2][k] = 32'h40000000;
         z_exp[3][k] = 32'hBF800000;
      end
      run_job("scale", 59, 1'b0, 1'b0);
      check("scale_div_reqs", div_reqs, N);

      // Spurious start and product pulse: result and timing unchanged.
      randomize_data();
      build_model();
      run_job("spur", 59, 1'b1, 1'b0);

      // Random 1..6 cycle latencies on every response port.
      rand_lat = 1'b1;
      for (int n = 0; n < 4; n++) begin
         randomize_data();
         build_model();
         run_job($sformatf("rlat%0d", n), -1, 1'b0, 1'b0);
      end
      rand_lat = 1'b0;

      // Reset during the second write of column 1, then a fresh job.
      randomize_data();
      build_model();
      run_job("abort", 59, 1'b0, 1'b1);
      randomize_data();
      build_model();
      run_job("fresh", 59, 1'b0, 1'b0);

`ifdef DIAG_SCALER_ZERO_CHECK_EN
      // Zero diagonal in row 1: no divide for it, row 1 of Z is 0, flag sticky.
      randomize_data();
      a_mat[0][0] = ONE;
      a_mat[1][1] = 32'd0;
      a_mat[2][2] = ONE;
      a_mat[3][3] = ONE;
      for (int r = 0; r < N; r++)
         for (int k = 0; k < M; k++) y_mat[r][k][31] = 1'b0;
      build_model();
      for (int k = 0; k < M; k++) z_exp[1][k] = 32'd0;
      run_job("zero", 54, 1'b0, 1'b0);
      check("zero_div_reqs", div_reqs, N - 1);
      check("zero_err_set", diag_zero_err, 1);
      repeat (5) @(negedge clk);
      check("zero_err_sticky", diag_zero_err, 1);
      randomize_data();
      build_model();
      run_job("after_zero", 59, 1'b0, 1'b0);
      check("after_zero_err", diag_zero_err, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/diag_scaler.md
# diag_scaler

Diagonal scaling stage of the LDLᵀ solve chain. It sits between the forward pass of the triangular solver (L·Y = B) and the backward pass (Lᵀ·X = Z) and computes Z = D⁻¹·Y. D is the diagonal of the packed factor matrix A, whose unit diagonal of L is implicit. The block builds a reciprocal vector of diag(A) once using the shared fp divider. It then scales Y column by column through the shared vector-mult ALU in elementwise mode, and writes Z one element per cycle.

## Interface
- N, 4, rows of A/Y/Z
- M, 3, columns of Y/Z
- WIDTH, 32, scalar bit width
- FP_ONE, 32'h3F800000, fp constant 1.0 used as divider numerator
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset: asynchronous, active-low
- start  in  1  sampled in IDLE only
- finished  out  1  one-cycle pulse in DONE
- a_row_addr  out  clog2(N)  row index i
- a_row_addr_ready  out  1  one-cycle read request
- a_row_valid  in  1  row data valid
- a_row_out  in  N*WIDTH  row i; element j at [j*WIDTH +: WIDTH]
- div_num / div_den  out  WIDTH each  numerator (FP_ONE) and denominator (d_i)
- div_ready  out  1  one-cycle divide request
- div_out  in  WIDTH  quotient
- div_valid  in  1  quotient valid
- vector_mult_in_a / vector_mult_in_b  out  N*WIDTH each  Y column and reciprocal vector
- vector_mult_ready  out  1  one-cycle multiply request
- vector_mult_out  in  N*WIDTH  elementwise product
- vector_mult_valid  in  1  product valid
- dot_product_mode  out  1  constant 0 (elementwise mode)
- y_col_addr  out  clog2(M)  column index k
- y_col_addr_ready  out  1  one-cycle read request
- y_col_valid  in  1  column data valid
- y_col_out  in  N*WIDTH  column k of Y
- z_write_row_addr / z_write_col_addr  out  clog2(N) / clog2(M)  element address
- z_write_data  out  WIDTH  element value
- z_write_ready  out  1  write strobe
- diag_zero_err  out  1  sticky; present only with the macro

## Operation
- **IDLE**
  - Counters i, j, k are zeroed.
  - On start, go to D_REQ.
- **D_REQ** (1 cycle)
  - Drive a_row_addr = i and a_row_addr_ready = 1, then go to D_WAIT.
- **D_WAIT**
  - On a_row_valid, capture d = a_row_out[i*WIDTH +: WIDTH] and go to D_ISSUE.
- **D_ISSUE** (1 cycle)
  - Drive div_ready = 1, div_num = FP_ONE, div_den = d, then go to D_DIV.
- **D_DIV**
  - On div_valid, store inv_d[i] = div_out.
  - If i == N−1, go to Y_REQ; otherwise increment i and go to D_REQ.
- **Y_REQ** (1 cycle)
  - Drive y_col_addr = k and y_col_addr_ready = 1, then go to Y_WAIT.
- **Y_WAIT**
  - On y_col_valid, register y_col_out into ybuf and go to V_ISSUE.
- **V_ISSUE** (1 cycle)
  - Drive vector_mult_ready = 1, in_a = ybuf, in_b = {inv_d[N−1..0]}, then go to V_WAIT.
- **V_WAIT**
  - On vector_mult_valid, register vector_mult_out into zbuf, clear j, and go to WRITE.
- **WRITE** (N cycles)
  - Each cycle: z_write_ready = 1, row = j, col = k, data = zbuf[j*WIDTH +: WIDTH]; then increment j.
  - When j == N−1: if k == M−1 go to DONE, otherwise increment k and go to Y_REQ.
- **DONE**
  - finished = 1, then go to IDLE.
- Reciprocals are the only stored state besides the buffers; each diagonal is divided exactly once.
- start outside IDLE is ignored. A valid input arriving in any state not waiting for it is ignored.
- Reset values: every output 0; state = IDLE; i = j = k = 0.
- Assertion of rst at any point (mid-operation included) forces IDLE. No request or write strobe is emitted in the cycle after reset deassertion.

## Timing
- Ld = divider latency (div_ready cycle to div_valid cycle, ≥ 1).
- Lv = vector-mult latency (≥ 1).
- Lm = memory read latency (≥ 1).
- Per diagonal: 2 + Lm + Ld cycles.
- Per column: 2 + Lm + Lv + N cycles.
- finished rises 1 + N·(2+Lm+Ld) + M·(2+Lm+Lv+N) cycles after the start cycle.
- Example: N=4, M=3, Lm=1, Ld=4, Lv=3 gives finished at cycle 59.
- Request outputs never stay high for more than one cycle.
- Z writes within a column are back-to-back with no gaps.

## Configuration
- Macro: DIAG_SCALER_ZERO_CHECK_EN.
- **Defined:**
  - In D_WAIT, if d[WIDTH−2:0] == 0 (±0.0), store inv_d[i] = 0, skip D_ISSUE/D_DIV, and go straight to the next-i decision. That diagonal costs 1 + Lm cycles instead of 2 + Lm + Ld.
  - diag_zero_err is set sticky and cleared only by reset or by accepted start.
- **Undefined:**
  - Port diag_zero_err is absent.
  - The divider is always invoked; zero diagonals yield whatever div_out returns (±inf).

## Test plan
- **Identity:** A = I, Y = [[1,2,3],[4,5,6],[7,8,9],[10,11,12]], N=4, M=3, Lm=1, Ld=4, Lv=3 → Z == Y; finished at cycle 59; exactly 12 writes, ordered row 0..3 within each column 0..2.
- **Scaling:** diag(A) = {2.0, 4.0, 0.5, −1.0}, Y all 1.0 → columns of Z equal {0.5, 0.25, 2.0, −1.0}; 4 div requests total, all with div_num = 32'h3F800000.
- **Variable latency:** random 1–6 cycle stalls on a_row_valid, div_valid, y_col_valid and vector_mult_valid → same Z values; at most one outstanding request per port.
- **Reset mid-run:** assert rst during the second WRITE cycle of column 1 → all outputs 0 immediately; no further writes; a fresh start completes correctly.
- **Spurious inputs:** pulse start while busy, and pulse vector_mult_valid in D_DIV → ignored; result and cycle count unchanged.
- **Zero check (macro defined):** diag(A) = {1.0, 0.0, 1.0, 1.0} → 3 div requests; row 1 of Z = 0; diag_zero_err = 1 until the next start.
